yarvi_fetch: RTL and testbench
==============================

Name: yarvi_fetch

Overview:
- Front end of the yarvi pipeline: generates the fetch PC, issues in-order instruction-memory reads and buffers returned words in a small FIFO.
- Presents (pc, insn) with a valid/ready handshake to the stage that drives the execute stage's pc/insn inputs.
- Consumes the execute stage's restart/restart_pc redirect, flushing buffered and in-flight fetches.

Parameters:
- ADDR_W, 32, width of the virtual PC and the imem address.
- INIT_PC, 32'h8000_0000, first fetch address after reset; low 2 bits must be 0.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, 2..16.
- MAX_OUTSTANDING, 2, maximum imem requests accepted but not yet answered, counting requests pending drop; 1..FIFO_DEPTH.

Ports:
- clock  in  1  single clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_restart  in  1  redirect pulse from execute.
- ex_restart_pc  in  ADDR_W  redirect target; bits [1:0] ignored.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_W  word-aligned fetch address.
- imem_resp_valid  in  1  read data valid; responses return in order, at least 1 cycle after acceptance, and are never back-pressured.
- imem_resp_data  in  32  instruction word.
- fe_valid  out  1  fe_pc/fe_insn hold a valid instruction.
- fe_ready  in  1  consumer takes the instruction.
- fe_pc  out  ADDR_W  PC of the presented instruction.
- fe_insn  out  32  presented instruction.
- fe_stall_cycles  out  32  present only with YARVI_FETCH_STALL_CNT_EN.

Behaviour:
- Async reset:
  - fetch_pc = INIT_PC; FSM = BOOT; FIFO empty; inflight = 0; drop = 0.
  - imem_req_valid = 0; fe_valid = 0; fe_pc = 0; fe_insn = 0.
- FSM:
  - BOOT: exactly 1 cycle after reset release, no requests. Then RUN.
  - RUN: normal operation; only reset leaves RUN.
  - ex_restart during BOOT sets fetch_pc only.
- Issue rule:
  - imem_req_valid = RUN && !ex_restart && (inflight + drop < MAX_OUTSTANDING) && (inflight + fifo_count < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4 (wraps modulo 2^ADDR_W); inflight += 1; fetch_pc is pushed into an in-order tag queue.
- Response handling:
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise: pop the tag, push {tag, data} into the FIFO, inflight -= 1.
  - The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
- Output:
  - fe_valid = FIFO not empty; fe_pc/fe_insn come from the FIFO head (registers, no combinational path from imem_resp).
  - Pop on fe_valid && fe_ready.
  - Latency: response in cycle N makes fe_valid high in cycle N+1 (FIFO was empty).
  - Throughput: 1 instr/cycle sustained when the memory has 1-cycle latency and MAX_OUTSTANDING >= 2.
- ex_restart (evaluated at the clock edge):
  - fetch_pc <= {ex_restart_pc[ADDR_W-1:2], 2'b00}.
  - FIFO and tag queue cleared; any pop in that cycle has no effect.
  - drop <= drop + inflight − (1 if a dropped response arrives this cycle); inflight <= 0.
  - No request is issued in the restart cycle.
  - A response arriving in the restart cycle belongs to the old stream and is discarded.
- Back-to-back restarts: each restart overrides the previous one; the last target wins and drop accumulates correctly.
- fe_ready low: FIFO fills, then issue stops via the credit rule. fetch_pc does not advance without an accepted request.
- imem_req_valid may drop without acceptance only on restart; otherwise it stays high until accepted, with a stable address.

Optional Feature:
- Macro: YARVI_FETCH_STALL_CNT_EN.
- Enabled:
  - fe_stall_cycles is reset to 0 and increments (wrapping) every RUN cycle where fe_valid=0 && fe_ready=1.
  - Counting continues across restarts.
- Disabled: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset release, 1-cycle memory, fe_ready=1 → first request addr 0x8000_0000 in the cycle after BOOT; fe_pc 0x8000_0000, 0x8000_0004, 0x8000_0008… at 1/cycle with the matching fe_insn.
- fe_ready=0 for 20 cycles → exactly FIFO_DEPTH=4 responses buffered, imem_req_valid=0; on release the 4 entries drain in order, then streaming resumes at 0x8000_0010.
- 2 requests in flight (memory latency 3), ex_restart with ex_restart_pc=0x0000_0103 → both old responses discarded; next request addr 0x0000_0100; first fe_pc=0x0000_0100.
- ex_restart in the same cycle as imem_resp_valid, then another restart 1 cycle later to 0x200 → no stale instruction ever appears; first fe_pc=0x200.
- imem_req_ready held low for 5 cycles → imem_req_valid stays high with constant addr; fetch_pc advances only on acceptance.
- With YARVI_FETCH_STALL_CNT_EN, memory latency 3, single outstanding request, fe_ready=1 → fe_stall_cycles increases by 3 per instruction (first request after BOOT) and matches the bench's reference count.

Source files
------------

// File: rtl/yarvi_fetch.sv
// yarvi_fetch: front end of the yarvi pipeline.
// Generates the fetch PC, issues in-order imem reads under a credit rule,
// tags each request with its PC, and buffers {pc, insn} pairs in a small FIFO
// that feeds the consumer through a valid/ready handshake. ex_restart flushes
// the buffer and turns every in-flight request into a pending drop.
// Optional feature macro: YARVI_FETCH_STALL_CNT_EN adds fe_stall_cycles, a
// count of RUN cycles where the consumer was ready but nothing was presented.
module yarvi_fetch #(
    parameter int                ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] INIT_PC         = 32'h8000_0000,
    parameter int                FIFO_DEPTH      = 4,
    parameter int                MAX_OUTSTANDING = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_restart,
    input  logic [ADDR_W-1:0] ex_restart_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    output logic              fe_valid,
    input  logic              fe_ready,
    output logic [ADDR_W-1:0] fe_pc,
    output logic [31:0]       fe_insn
`ifdef YARVI_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]       fe_stall_cycles
`endif
);

    // Pointer width for the power-of-two queues; counters get two extra bits
    // so sums like inflight + fifo_cnt never overflow.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc;

    // In-order tag queue: PC of every live request awaiting its response.
    logic [ADDR_W-1:0] tag_q [FIFO_DEPTH];
    logic [PW-1:0]     tag_wr, tag_rd;

    // Instruction buffer.
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [31:0]       fifo_insn [FIFO_DEPTH];
    logic [PW-1:0]     fifo_wr, fifo_rd;
    logic [CW-1:0]     fifo_cnt;

    // inflight: live requests; drop: requests whose responses must be discarded.
    logic [CW-1:0]     inflight, drop;

    logic req_fire, resp_keep, fe_pop;

    assign req_fire  = imem_req_valid && imem_req_ready;
    // A response is kept only when it is not owed to a drop and no restart is
    // flushing the stream this cycle.
    assign resp_keep = imem_resp_valid && (drop == '0) && !ex_restart;
    assign fe_pop    = fe_valid && fe_ready && !ex_restart;

    assign imem_req_addr = fetch_pc;
    assign fe_valid      = (fifo_cnt != '0);
    assign fe_pc         = fifo_pc[fifo_rd];
    assign fe_insn       = fifo_insn[fifo_rd];

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= BOOT;
        else          state <= state_nxt;
    end

    // Next state and the credit-gated request valid.
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (!ex_restart && (inflight + drop < MAX_OUT_C) &&
                    (inflight + fifo_cnt < DEPTH_C))
                    imem_req_valid = 1'b1;
            end
            default: state_nxt = BOOT;
        endcase
    end

    // Fetch PC: redirect wins, otherwise advance only on an accepted request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        fetch_pc <= INIT_PC;
        else if (ex_restart) fetch_pc <= {ex_restart_pc[ADDR_W-1:2], 2'b00};
        else if (req_fire)   fetch_pc <= fetch_pc + ADDR_W'(4);
    end

    // Tag queue storage; contents are only read behind valid pointers.
    always_ff @(posedge clock) begin
        if (req_fire) tag_q[tag_wr] <= fetch_pc;
    end

    // Tag queue pointers, cleared by a restart.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else if (ex_restart) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (req_fire)  tag_wr <= tag_wr + PW'(1);
            if (resp_keep) tag_rd <= tag_rd + PW'(1);
        end
    end

    // Outstanding accounting; a restart converts every live request into a
    // drop, minus the response (old stream) that may be arriving right now.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
            drop     <= '0;
        end else if (ex_restart) begin
            inflight <= '0;
            drop     <= drop + inflight - CW'(imem_resp_valid);
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(resp_keep);
            if (imem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
        end
    end

    // Instruction FIFO; storage is reset so the presented pair reads 0 after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_insn[i] <= '0;
            end
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else if (ex_restart) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            assert (!(resp_keep && !fe_pop && fifo_cnt == DEPTH_C));
            if (resp_keep) begin
                fifo_pc[fifo_wr]   <= tag_q[tag_rd];
                fifo_insn[fifo_wr] <= imem_resp_data;
                fifo_wr            <= fifo_wr + PW'(1);
            end
            if (fe_pop) fifo_rd <= fifo_rd + PW'(1);
            fifo_cnt <= fifo_cnt + CW'(resp_keep) - CW'(fe_pop);
        end
    end

`ifdef YARVI_FETCH_STALL_CNT_EN
    // Starvation counter: consumer ready, nothing to present, while running.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            fe_stall_cycles <= '0;
        else if (state == RUN && !fe_valid && fe_ready)
            fe_stall_cycles <= fe_stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_yarvi_fetch.sv
// tb_yarvi_fetch: randomized bench for yarvi_fetch with a memory model and a
// stream-level reference: after each redirect the consumer must see the target
// PC followed by consecutive words, each carrying the memory's word for it.
// Also honours YARVI_FETCH_STALL_CNT_EN for the stall counter.
module tb_yarvi_fetch;

    localparam int          MAX_OUT = 2;
    localparam logic [31:0] INIT    = 32'h8000_0000;

    logic        clock, reset_n;
    logic        ex_restart;
    logic [31:0] ex_restart_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fe_valid, fe_ready;
    logic [31:0] fe_pc, fe_insn;
`ifdef YARVI_FETCH_STALL_CNT_EN
    logic [31:0] fe_stall_cycles;
`endif

    yarvi_fetch dut (
        .clock(clock), .reset_n(reset_n),
        .ex_restart(ex_restart), .ex_restart_pc(ex_restart_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .fe_valid(fe_valid), .fe_ready(fe_ready),
        .fe_pc(fe_pc), .fe_insn(fe_insn)
`ifdef YARVI_FETCH_STALL_CNT_EN
        , .fe_stall_cycles(fe_stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;

    mreq_t       pend_q[$];   // accepted by memory, not yet answered
    ent_t        exp_q[$];    // instructions the consumer should currently see
    int          epoch, cyc, pops;
    logic [31:0] req_pc, exp_pc, stall_ref;
    int          n_chk, n_fail;

    // memory / consumer behaviour knobs
    int lat_lo, lat_hi, rdy_pct, fr_pct;
    bit single_out;

    // last observed DUT values
    bit          last_req_v, last_fe_v, prev_stall;
    logic [31:0] last_req_a, last_fe_pc, last_fe_insn, prev_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit resp_due();
        return (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        ex_restart = 1'b0; ex_restart_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        fe_ready = 1'b0;
        #1;
        chk("rst_req_v", 32'(imem_req_valid), 32'd0);
        chk("rst_fe_v", 32'(fe_valid), 32'd0);
        chk("rst_fe_pc", fe_pc, 32'd0);
        chk("rst_fe_insn", fe_insn, 32'd0);
`ifdef YARVI_FETCH_STALL_CNT_EN
        chk("rst_stall", fe_stall_cycles, 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        pend_q.delete(); exp_q.delete();
        epoch = 0; cyc = 0; req_pc = INIT; exp_pc = INIT; stall_ref = '0;
        prev_stall = 1'b0;
    endtask

    // One clock cycle: drive inputs, observe, update the reference at the edge.
    task automatic step(input bit rs, input logic [31:0] rpc);
        bit rdy, fr, rv;
        rdy = ($urandom_range(99) < rdy_pct) && (!single_out || pend_q.size() == 0);
        fr  = ($urandom_range(99) < fr_pct);
        rv  = resp_due();
        ex_restart      = rs;
        ex_restart_pc   = rs ? rpc : $urandom;
        imem_req_ready  = rdy;
        fe_ready        = fr;
        imem_resp_valid = rv;
        imem_resp_data  = rv ? memf(pend_q[0].addr) : $urandom;
        #1;
        last_req_v = imem_req_valid; last_req_a = imem_req_addr;
        last_fe_v = fe_valid; last_fe_pc = fe_pc; last_fe_insn = fe_insn;

        if (cyc == 0 || rs) chk("no_req", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid) chk("req_addr", imem_req_addr, req_pc);
        if (prev_stall && !rs) begin
            chk("req_hold", 32'(imem_req_valid), 32'd1);
            chk("req_same", imem_req_addr, prev_addr);
        end
        chk("fe_valid", 32'(fe_valid), 32'(exp_q.size() != 0));
`ifdef YARVI_FETCH_STALL_CNT_EN
        chk("stall_cnt", fe_stall_cycles, stall_ref);
        if (cyc >= 1 && exp_q.size() == 0 && fr) stall_ref = stall_ref + 32'd1;
`endif

        if (rs) begin
            exp_q.delete();
            epoch++;
            req_pc = {rpc[31:2], 2'b00};
            exp_pc = req_pc;
        end else begin
            if (fe_valid && fr) begin
                pops++;
                chk("fe_pc_seq", fe_pc, exp_pc);
                chk("fe_insn", fe_insn, memf(exp_pc));
                if (exp_q.size() > 0) begin
                    chk("fe_pc_q", fe_pc, exp_q[0].pc);
                    void'(exp_q.pop_front());
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (imem_req_valid && rdy) begin
                chk("outstanding", 32'(pend_q.size() < MAX_OUT), 32'd1);
                pend_q.push_back('{addr: imem_req_addr, ep: epoch,
                                   due: cyc + int'($urandom_range(lat_hi, lat_lo))});
                req_pc = req_pc + 32'd4;
            end
            if (rv && pend_q[0].ep == epoch)
                exp_q.push_back('{pc: pend_q[0].addr, insn: memf(pend_q[0].addr)});
        end
        if (rv) void'(pend_q.pop_front());
        prev_stall = imem_req_valid && !rdy;
        prev_addr  = imem_req_addr;
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    initial begin
        int p0;
        n_chk = 0; n_fail = 0; pops = 0;
        reset_n = 1'b0;
        lat_lo = 1; lat_hi = 1; rdy_pct = 100; fr_pct = 100; single_out = 0;
        do_reset();

        // streaming at one instruction per cycle with a 1-cycle memory
        step(0, 0);                                   // BOOT
        step(0, 0);
        chk("first_req_v", 32'(last_req_v), 32'd1);
        chk("first_req_a", last_req_a, INIT);
        step(0, 0);
        for (int i = 3; i <= 20; i++) begin
            step(0, 0);
            chk("thru", 32'(last_fe_v), 32'd1);
            if (i == 3) begin
                chk("first_pc", last_fe_pc, INIT);
                chk("first_insn", last_fe_insn, memf(INIT));
            end
        end

        // consumer stalled: buffer fills, credits stop the issue
        fr_pct = 0;
        for (int i = 0; i < 20; i++) step(0, 0);
        chk("credit_stop", 32'(last_req_v), 32'd0);
        chk("buf_valid", 32'(last_fe_v), 32'd1);
        fr_pct = 100; rdy_pct = 0; p0 = pops;
        for (int i = 0; i < 6; i++) step(0, 0);
        chk("buf_drain4", 32'(pops - p0), 32'd4);

        // memory not ready: request held with a stable address
        chk("hold_pre_v", 32'(last_req_v), 32'd1);
        p0 = int'(last_req_a);
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            chk("hold_v", 32'(last_req_v), 32'd1);
            chk("hold_a", last_req_a, 32'(p0));
        end
        rdy_pct = 100;

        // redirect with two requests in flight
        lat_lo = 3; lat_hi = 3;
        for (int n = 0; n < 20 && pend_q.size() != 2; n++) step(0, 0);
        chk("two_inflight", 32'(pend_q.size()), 32'd2);
        step(1, 32'h0000_0103);
        for (int n = 0; n < 10; n++) begin step(0, 0); if (last_req_v) break; end
        chk("rst_req", 32'(last_req_v), 32'd1);
        chk("rst_addr", last_req_a, 32'h0000_0100);
        for (int n = 0; n < 20; n++) begin step(0, 0); if (last_fe_v) break; end
        chk("rst_fe_v", 32'(last_fe_v), 32'd1);
        chk("rst_fe_pc", last_fe_pc, 32'h0000_0100);

        // redirect coinciding with a response, then a second redirect
        lat_lo = 2; lat_hi = 2;
        for (int n = 0; n < 20 && !resp_due(); n++) step(0, 0);
        chk("rr_sync", 32'(resp_due()), 32'd1);
        step(1, 32'h0000_0300);
        step(1, 32'h0000_0200);
        for (int n = 0; n < 20; n++) begin step(0, 0); if (last_fe_v) break; end
        chk("rr_fe_v", 32'(last_fe_v), 32'd1);
        chk("rr_fe_pc", last_fe_pc, 32'h0000_0200);

        // single outstanding request, 3-cycle memory (stall counter scenario)
        do_reset();
        single_out = 1; lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 40; i++) step(0, 0);
        single_out = 0;

        // randomized traffic with occasional redirects
        lat_lo = 1; lat_hi = 4; rdy_pct = 70; fr_pct = 70;
        for (int i = 0; i < 1500; i++)
            step($urandom_range(99) < 5, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
